// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with zero register, write-port priority, optional write-to-read bypass and busy scoreboard
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter int NWR = 1,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic                issue_en_i,
  input  logic [AW-1:0]       issue_addr_i,
  output logic [NREGS-1:0]    busy_vec_o
);
  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  // Ascending port order lets the highest-index write win; issue is applied last so it beats a clear.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en_i[w] && wr_addr_i[w*AW +: AW] != '0) begin
        regs_d[wr_addr_i[w*AW +: AW]] = wr_data_i[w*XLEN +: XLEN];
        busy_d[wr_addr_i[w*AW +: AW]] = 1'b0;
      end
    end
    if (issue_en_i && issue_addr_i != '0) busy_d[issue_addr_i] = 1'b1;
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end
  assign busy_vec_o = busy_q;
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   a;
    logic            hit;
    logic [XLEN-1:0] fwd;
    assign a = rd_addr_i[p*AW +: AW];
    always_comb begin
      hit = 1'b0;
      fwd = '0;
      for (int w = 0; w < NWR; w++) begin
        if (BYPASS != 0 && wr_en_i[w] && wr_addr_i[w*AW +: AW] == a && a != '0) begin
          hit = 1'b1;
          fwd = wr_data_i[w*XLEN +: XLEN];
        end
      end
    end
    // While rst is high the reads already present the cleared state.
    assign rd_data_o[p*XLEN +: XLEN] = (rst || a == '0) ? '0 : hit ? fwd : regs_q[a];
    assign rd_busy_o[p] = !rst && a != '0 && !hit && busy_q[a];
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and random checks of regfile_mp (bypass and non-bypass instances) against a behavioural model
module tb_regfile_mp;
  localparam int XLEN = 32, NREGS = 64, AW = 6, NRD = 3, NWR = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data, rd_data_n;
  logic [NRD-1:0]      rd_busy, rd_busy_n;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                issue_en;
  logic [AW-1:0]       issue_addr;
  logic [NREGS-1:0]    busy_vec, busy_vec_n;
  int checks = 0, errors = 0;
  bit chk_on = 1'b0;
  logic [XLEN-1:0] m_mem [NREGS];
  bit              m_busy [NREGS];

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .issue_en_i(issue_en), .issue_addr_i(issue_addr), .busy_vec_o(busy_vec));
  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_n), .rd_busy_o(rd_busy_n),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .issue_en_i(issue_en), .issue_addr_i(issue_addr), .busy_vec_o(busy_vec_n));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] we, input int a0, input logic [31:0] d0, input int a1,
                       input logic [31:0] d1, input logic ie, input int ia, input int r0, input int r1, input int r2);
    wr_en = we;
    wr_addr = {a1[5:0], a0[5:0]};
    wr_data = {d1, d0};
    issue_en = ie;
    issue_addr = ia[5:0];
    rd_addr = {r2[5:0], r1[5:0], r0[5:0]};
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Architectural model: registers and busy flags updated from the rules at each edge
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        m_mem[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      for (int w = 0; w < NWR; w++) begin
        int wa;
        wa = int'(wr_addr[w*AW +: AW]);
        if (wr_en[w] && wa != 0) begin
          m_mem[wa] = wr_data[w*XLEN +: XLEN];
          m_busy[wa] = 1'b0;
        end
      end
      if (issue_en && issue_addr != 0) m_busy[int'(issue_addr)] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      logic [63:0] bv;
      for (int p = 0; p < NRD; p++) begin
        int a;
        bit hit, ba, bb;
        logic [31:0] fwd, ea, eb;
        a = int'(rd_addr[p*AW +: AW]);
        hit = 1'b0;
        fwd = '0;
        for (int w = NWR - 1; w >= 0; w--) begin
          if (!hit && wr_en[w] && int'(wr_addr[w*AW +: AW]) == a && a != 0) begin
            hit = 1'b1;
            fwd = wr_data[w*XLEN +: XLEN];
          end
        end
        ea = (rst || a == 0) ? 32'h0 : hit ? fwd : m_mem[a];
        eb = (rst || a == 0) ? 32'h0 : m_mem[a];
        ba = !rst && a != 0 && !hit && m_busy[a];
        bb = !rst && a != 0 && m_busy[a];
        check($sformatf("byp_rd_data[%0d]", p), 64'(rd_data[p*XLEN +: XLEN]), 64'(ea));
        check($sformatf("nobyp_rd_data[%0d]", p), 64'(rd_data_n[p*XLEN +: XLEN]), 64'(eb));
        check($sformatf("byp_rd_busy[%0d]", p), 64'(rd_busy[p]), 64'(ba));
        check($sformatf("nobyp_rd_busy[%0d]", p), 64'(rd_busy_n[p]), 64'(bb));
      end
      for (int i = 0; i < NREGS; i++) bv[i] = m_busy[i];
      check("byp_busy_vec", busy_vec, bv);
      check("nobyp_busy_vec", busy_vec_n, bv);
    end
  end

  initial begin
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_on = 1'b1;
    // reset drops earlier writes and issues
    drive(2'b01, 5, 32'hDEADBEEF, 0, 0, 1'b1, 6, 5, 0, 0);
    @(negedge clk);
    check("t1_byp_same_cycle", 64'(rd_data[31:0]), 64'hDEADBEEF);
    check("t1_nobyp_same_cycle", 64'(rd_data_n[31:0]), 64'h0);
    tick;
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5, 0, 0);
    @(negedge clk);
    check("t1_stored", 64'(rd_data[31:0]), 64'hDEADBEEF);
    check("t1_busy_r6", busy_vec, 64'h40);
    tick;
    rst = 1'b1;
    @(negedge clk);
    check("t1_rd_during_rst", 64'(rd_data[31:0]), 64'h0);
    tick;
    rst = 1'b0;
    @(negedge clk);
    check("t1_rd_after_rst", 64'(rd_data[31:0]), 64'h0);
    check("t1_busy_after_rst", busy_vec, 64'h0);
    tick;
    // register zero
    drive(2'b01, 0, 32'h1234, 0, 0, 1'b1, 0, 0, 0, 0);
    @(negedge clk);
    check("t2_r0_byp", 64'(rd_data[31:0]), 64'h0);
    check("t2_r0_busy", 64'(rd_busy[0]), 64'h0);
    tick;
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0, 0);
    @(negedge clk);
    check("t2_r0_stored", 64'(rd_data_n[31:0]), 64'h0);
    check("t2_busy_vec", busy_vec, 64'h0);
    tick;
    // bypass vs no bypass
    drive(2'b01, 7, 32'h11110000, 0, 0, 1'b0, 0, 0, 7, 0);
    tick;
    drive(2'b01, 7, 32'hA5A50001, 0, 0, 1'b0, 0, 0, 7, 0);
    @(negedge clk);
    check("t3_byp_new", 64'(rd_data[63:32]), 64'hA5A50001);
    check("t3_nobyp_old", 64'(rd_data_n[63:32]), 64'h11110000);
    tick;
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 7, 0);
    @(negedge clk);
    check("t3_nobyp_next", 64'(rd_data_n[63:32]), 64'hA5A50001);
    tick;
    // write port conflict
    drive(2'b11, 3, 32'h11, 3, 32'h22, 1'b0, 0, 0, 0, 3);
    @(negedge clk);
    check("t4_byp_conflict", 64'(rd_data[95:64]), 64'h22);
    tick;
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0, 3);
    @(negedge clk);
    check("t4_stored_byp", 64'(rd_data[95:64]), 64'h22);
    check("t4_stored_nobyp", 64'(rd_data_n[95:64]), 64'h22);
    tick;
    // scoreboard
    drive(2'b00, 0, 0, 0, 0, 1'b1, 9, 9, 0, 0);
    tick;
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 9, 0, 0);
    @(negedge clk);
    check("t5_busy9_set", 64'(busy_vec[9]), 64'h1);
    check("t5_rd_busy", 64'(rd_busy[0]), 64'h1);
    tick;
    drive(2'b10, 0, 0, 9, 32'h5, 1'b1, 9, 9, 0, 0);
    @(negedge clk);
    check("t5_byp_busy_fwd", 64'(rd_busy[0]), 64'h0);
    check("t5_nobyp_busy", 64'(rd_busy_n[0]), 64'h1);
    tick;
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 9, 0, 0);
    @(negedge clk);
    check("t5_issue_beats_write", 64'(busy_vec[9]), 64'h1);
    tick;
    drive(2'b10, 0, 0, 9, 32'h7, 1'b0, 0, 9, 0, 0);
    tick;
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 9, 0, 0);
    @(negedge clk);
    check("t5_busy9_cleared", 64'(busy_vec[9]), 64'h0);
    check("t5_r9_value", 64'(rd_data[31:0]), 64'h7);
    tick;
    // random traffic with occasional reset pulses
    for (int n = 0; n < 10000; n++) begin
      int ad [6];
      for (int k = 0; k < 6; k++) ad[k] = $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 63);
      rst = ($urandom_range(0, 199) == 0);
      drive(2'($urandom_range(0, 3)), ad[0], $urandom, ad[1], $urandom, 1'($urandom_range(0, 1)), ad[2], ad[3], ad[4], ad[5]);
      tick;
    end
    rst = 1'b0;
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0, 0);
    @(negedge clk);
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
